hcsr04_emulator: RTL

//   Responder side of the HC-SR04 ultrasonic trig/echo protocol: emulates the sensor.

---
 rtl/hcsr04_emulator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hcsr04_emulator.sv
// rtl/hcsr04_emulator.sv - HC-SR04 ultrasonic sensor emulator (trig in, echo out)
//
// Purpose: responds to a trigger pulse on trig_i like an HC-SR04 sensor. After an
// emulated acoustic burst delay it drives an echo pulse whose width in microseconds
// equals the distance value commanded on echo_us_i.
//
// Ports:
//   clk_i         system clock
//   reset_i       asynchronous, active-high reset
//   trig_i        trigger pin, asynchronous to clk_i
//   echo_us_i     commanded echo width in us, sampled when a trigger is accepted
//   echo_o        echo pin (registered)
//   busy_o        high while the burst delay or the echo pulse is in progress
//   short_trig_o  1-cycle pulse when a trigger is rejected as too short
//   echo_count_o  number of completed echo pulses, wraps 255 -> 0
module hcsr04_emulator #(
  parameter int CLK_PER_US  = 40,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = 38000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        trig_i,
  input  logic [15:0] echo_us_i,
  output logic        echo_o,
  output logic        busy_o,
  output logic        short_trig_o,
  output logic [7:0]  echo_count_o
);

  localparam logic [15:0] TRIG_CLKS  = 16'(MIN_TRIG_US * CLK_PER_US);
  localparam logic [15:0] PRESC_MAX  = 16'(CLK_PER_US - 1);
  localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    ECHO  = 2'd2
  } state_t;

  state_t      state_q;
  logic        trig_meta_q;
  logic        trig_s_q;
  logic        trig_prev_q;
  logic        armed_q;
  logic [15:0] hcnt_q;
  logic [15:0] presc_q;
  logic [15:0] us_q;
  logic [15:0] width_q;
  logic        echo_q;
  logic        busy_q;
  logic        short_trig_q;
  logic [7:0]  echo_count_q;

  logic        trig_rise;
  logic        trig_fall;
  logic        presc_wrap;
  logic [15:0] width_sel;

  always_comb begin
    trig_rise  = trig_s_q & ~trig_prev_q;
    trig_fall  = ~trig_s_q & trig_prev_q;
    presc_wrap = (presc_q == PRESC_MAX);
    // Zero or out-of-range distances report the "no obstacle" width.
    if ((echo_us_i == 16'd0) || (echo_us_i > TIMEOUT_W)) begin
      width_sel = TIMEOUT_W;
    end else begin
      width_sel = echo_us_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      trig_meta_q  <= 1'b0;
      trig_s_q     <= 1'b0;
      trig_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      hcnt_q       <= 16'd0;
      presc_q      <= 16'd0;
      us_q         <= 16'd0;
      width_q      <= 16'd0;
      echo_q       <= 1'b0;
      busy_q       <= 1'b0;
      short_trig_q <= 1'b0;
      echo_count_q <= 8'd0;
    end else begin
      trig_meta_q  <= trig_i;
      trig_s_q     <= trig_meta_q;
      trig_prev_q  <= trig_s_q;
      short_trig_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (trig_rise) begin
            hcnt_q  <= 16'd0;
            armed_q <= 1'b1;
          end else if (armed_q && trig_s_q) begin
            if (hcnt_q != TRIG_CLKS) begin
              hcnt_q <= hcnt_q + 16'd1;
            end
          end else if (armed_q && trig_fall) begin
            // A trig already high when IDLE is re-entered never produces a rise,
            // so it stays unarmed until it falls and rises again.
            armed_q <= 1'b0;
            if (hcnt_q >= TRIG_CLKS) begin
              width_q <= width_sel;
              presc_q <= 16'd0;
              us_q    <= 16'd0;
              busy_q  <= 1'b1;
              state_q <= BURST;
            end else begin
              short_trig_q <= 1'b1;
            end
          end
        end

        BURST: begin
          presc_q <= presc_wrap ? 16'd0 : presc_q + 16'd1;
          if (presc_wrap) begin
            if (us_q == BURST_LAST) begin
              // us counter restarts so ECHO can compare directly against width_q.
              us_q    <= 16'd0;
              echo_q  <= 1'b1;
              state_q <= ECHO;
            end else begin
              us_q <= us_q + 16'd1;
            end
          end
        end

        ECHO: begin
          presc_q <= presc_wrap ? 16'd0 : presc_q + 16'd1;
          if (presc_wrap) begin
            if (us_q == width_q - 16'd1) begin
              echo_q       <= 1'b0;
              busy_q       <= 1'b0;
              echo_count_q <= echo_count_q + 8'd1;
              state_q      <= IDLE;
            end else begin
              us_q <= us_q + 16'd1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          echo_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign echo_o       = echo_q;
  assign busy_o       = busy_q;
  assign short_trig_o = short_trig_q;
  assign echo_count_o = echo_count_q;

endmodule
